// File: rtl/alu.sv
// alu: registered 8-bit two's-complement arithmetic/logic unit.
//
// Ports:
//   clk     - rising-edge clock
//   rst_n   - asynchronous active-low reset; clears C
//   A, B    - 8-bit signed operands
//   ALU_en  - global enable; C holds when low
//   a_en    - opcode set select (with b_en)
//   b_en    - opcode set select (with a_en)
//   a_op    - 3-bit opcode for set A    (a_en=1, b_en=0)
//   b_op    - 2-bit opcode for set B1/B2 (b_en=1)
//   C       - registered 8-bit result; updated one cycle after inputs are sampled
//
// The only state is the result register. Reserved opcodes, the a_en=b_en=0 no-op,
// and any unknown value on a selected control all resolve to "hold": every case
// below falls through to a default that keeps the current result.

module alu (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] A,
   input  logic [7:0] B,
   input  logic       ALU_en,
   input  logic       a_en,
   input  logic       b_en,
   input  logic [2:0] a_op,
   input  logic [1:0] b_op,
   output logic [7:0] C
);

   logic [7:0] c_q;
   logic [7:0] c_d;

   always_comb begin
      c_d = c_q;
      // case (not if) so an unknown ALU_en/a_en/b_en matches no item and holds
      case (ALU_en)
         1'b1: begin
            case ({a_en, b_en})
               2'b10: begin
                  case (a_op)
                     3'd0:    c_d = A + B;
                     3'd1:    c_d = A - B;
                     3'd2:    c_d = A ^ B;
                     3'd3:    c_d = A & B;
                     3'd4:    c_d = A & B;
                     3'd5:    c_d = A | B;
                     3'd6:    c_d = ~(A ^ B);
                     default: c_d = c_q;
                  endcase
               end
               2'b01: begin
                  case (b_op)
                     2'd0:    c_d = ~(A & B);
                     2'd1:    c_d = A + B;
                     2'd2:    c_d = A + B;
                     default: c_d = c_q;
                  endcase
               end
               2'b11: begin
                  case (b_op)
                     2'd0:    c_d = A ^ B;
                     2'd1:    c_d = ~(A ^ B);
                     2'd2:    c_d = A - 8'd1;
                     2'd3:    c_d = B + 8'd2;
                     default: c_d = c_q;
                  endcase
               end
               default: c_d = c_q;
            endcase
         end
         default: c_d = c_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c_q <= 8'h00;
      end else begin
         c_q <= c_d;
      end
   end

   assign C = c_q;

endmodule

// File: tb/tb_alu.sv
// tb_alu: directed and random stimulus for alu. A reference model computes the
// expected result from signed integer arithmetic; a compare process checks C on
// every falling edge, and directed steps also pin literal hand-computed values.

module tb_alu;

   logic       clk;
   logic       rst_n;
   logic [7:0] A;
   logic [7:0] B;
   logic       ALU_en;
   logic       a_en;
   logic       b_en;
   logic [2:0] a_op;
   logic [1:0] b_op;
   logic [7:0] C;

   int unsigned vectors    = 0;
   int unsigned miscompares = 0;

   logic [7:0] exp_c;
   logic [8:0] model_res;
   logic       checking = 1'b0;

   alu u_dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .A      (A),
      .B      (B),
      .ALU_en (ALU_en),
      .a_en   (a_en),
      .b_en   (b_en),
      .a_op   (a_op),
      .b_op   (b_op),
      .C      (C)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Returns {update, value}; update=0 means the result register must hold.
   function automatic logic [8:0] ref_op(input logic en, input logic ae, input logic be,
                                         input logic [2:0] ao, input logic [1:0] bo,
                                         input logic [7:0] a, input logic [7:0] b);
      int sa;
      int sb;
      int r;
      bit ok;
      sa = int'($signed(a));
      sb = int'($signed(b));
      r  = 0;
      ok = 1'b1;
      if (en !== 1'b1) begin
         ok = 1'b0;
      end else if (ae === 1'b1 && be === 1'b0) begin
         if      (ao === 3'd0) r = sa + sb;
         else if (ao === 3'd1) r = sa - sb;
         else if (ao === 3'd2) r = int'(a ^ b);
         else if (ao === 3'd3 || ao === 3'd4) r = int'(a & b);
         else if (ao === 3'd5) r = int'(a | b);
         else if (ao === 3'd6) r = 255 - int'(a ^ b);
         else ok = 1'b0;
      end else if (ae === 1'b0 && be === 1'b1) begin
         if      (bo === 2'd0) r = 255 - int'(a & b);
         else if (bo === 2'd1 || bo === 2'd2) r = sa + sb;
         else ok = 1'b0;
      end else if (ae === 1'b1 && be === 1'b1) begin
         if      (bo === 2'd0) r = int'(a ^ b);
         else if (bo === 2'd1) r = 255 - int'(a ^ b);
         else if (bo === 2'd2) r = sa - 1;
         else if (bo === 2'd3) r = sb + 2;
         else ok = 1'b0;
      end else begin
         ok = 1'b0;
      end
      r = r & 255;
      return {ok, r[7:0]};
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_c <= 8'h00;
      end else begin
         model_res = ref_op(ALU_en, a_en, b_en, a_op, b_op, A, B);
         if (model_res[8]) exp_c <= model_res[7:0];
      end
   end

   always @(negedge clk) begin
      if (checking) begin
         vectors++;
         if (C !== exp_c) begin
            miscompares++;
            $display("FAIL model_cmp t=%0t: C=%02h expected %02h", $time, C, exp_c);
         end
      end
   end

   task automatic check_lit(input string name, input logic [7:0] want);
      vectors++;
      if (C !== want) begin
         miscompares++;
         $display("FAIL %s: C=%02h expected %02h", name, C, want);
      end
   endtask

   // Apply inputs, then advance past the next rising edge.
   task automatic step(input logic en, input logic ae, input logic be,
                       input logic [2:0] ao, input logic [1:0] bo,
                       input logic [7:0] a, input logic [7:0] b);
      ALU_en = en; a_en = ae; b_en = be; a_op = ao; b_op = bo; A = a; B = b;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] held;
      int unsigned seed;
      rst_n = 1'b0;
      ALU_en = 1'b0; a_en = 1'b0; b_en = 1'b0; a_op = 3'd0; b_op = 2'd0;
      A = 8'h00; B = 8'h00;
      seed = $urandom(32'hC0FFEE);
      checking = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_lit("reset_state", 8'h00);
      rst_n = 1'b1;

      // Set A arithmetic
      step(1, 1, 0, 3'd0, 2'd0, 8'd100, 8'd50);  check_lit("add_wrap", 8'h96);
      step(1, 1, 0, 3'd1, 2'd0, 8'd5, 8'd10);    check_lit("sub_neg", 8'hFB);

      // Set A logic sweep
      step(1, 1, 0, 3'd2, 2'd0, 8'hF0, 8'h3C);   check_lit("a_xor", 8'hCC);
      step(1, 1, 0, 3'd3, 2'd0, 8'hF0, 8'h3C);   check_lit("a_and3", 8'h30);
      step(1, 1, 0, 3'd4, 2'd0, 8'hF0, 8'h3C);   check_lit("a_and4", 8'h30);
      step(1, 1, 0, 3'd5, 2'd0, 8'hF0, 8'h3C);   check_lit("a_or", 8'hFC);
      step(1, 1, 0, 3'd6, 2'd0, 8'hF0, 8'h3C);   check_lit("a_xnor", 8'h33);
      step(1, 1, 0, 3'd7, 2'd0, 8'hF0, 8'h3C);   check_lit("a_rsvd_hold", 8'h33);

      // Set B1
      step(1, 0, 1, 3'd0, 2'd0, 8'hF0, 8'h3C);   check_lit("b1_nand", 8'hCF);
      step(1, 0, 1, 3'd0, 2'd1, 8'hF0, 8'h3C);   check_lit("b1_add1", 8'h2C);
      step(1, 0, 1, 3'd0, 2'd0, 8'hF0, 8'h3C);   check_lit("b1_nand2", 8'hCF);
      step(1, 0, 1, 3'd7, 2'd2, 8'hF0, 8'h3C);   check_lit("b1_add2", 8'h2C);
      step(1, 0, 1, 3'd0, 2'd3, 8'h11, 8'h22);   check_lit("b1_rsvd_hold", 8'h2C);

      // Set B2
      step(1, 1, 1, 3'd0, 2'd2, 8'h80, 8'h00);   check_lit("b2_dec_wrap", 8'h7F);
      step(1, 1, 1, 3'd0, 2'd3, 8'h00, 8'h7F);   check_lit("b2_inc2", 8'h81);
      step(1, 1, 1, 3'd0, 2'd0, 8'hAA, 8'h0F);   check_lit("b2_xor", 8'hA5);
      step(1, 1, 1, 3'd0, 2'd1, 8'hAA, 8'h0F);   check_lit("b2_xnor", 8'h5A);

      // Enable gating: both forms hold for 5 cycles
      for (int i = 0; i < 5; i++) begin
         step(0, 1, 0, 3'd0, 2'd0, 8'h01, 8'h02);
         check_lit("alu_en_off_hold", 8'h5A);
      end
      for (int i = 0; i < 5; i++) begin
         step(1, 0, 0, 3'd0, 2'd1, 8'h03, 8'h04);
         check_lit("nop_hold", 8'h5A);
      end

      // Asynchronous reset mid-cycle, with C=5A
      #3;
      rst_n = 1'b0;
      #1;
      check_lit("async_reset", 8'h00);
      step(1, 1, 0, 3'd0, 2'd0, 8'h10, 8'h20);   check_lit("reset_held1", 8'h00);
      step(1, 1, 0, 3'd0, 2'd0, 8'h10, 8'h20);   check_lit("reset_held2", 8'h00);
      rst_n = 1'b1;
      step(1, 1, 0, 3'd0, 2'd0, 8'h10, 8'h20);   check_lit("after_release", 8'h30);

      // Random stream, checked against the model by the compare process
      held = 8'h30;
      for (int i = 0; i < 300; i++) begin
         step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
              8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      end
      if (held != 8'h30) $display("unexpected");

      @(negedge clk);
      checking = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
